// File: rtl/blood_sprite_draw.sv
// rtl/blood_sprite_draw.sv - HP sprite compositor with ROM latency compensation and hit blink
//
// Purpose: maps the VGA pixel position to a 64x64 sprite ROM address inside a fixed
// window, waits out the ROM's one-cycle read latency and composites opaque sprite
// pixels over bg_rgb. Colour 12'h000 is transparent. After a hit pulse the sprite
// blinks for BLINK_FRAMES*BLINK_TOGGLES frames, starting hidden and ending visible.
//
// Optional feature macro: BLOOD_FLASH_EN (opaque pixels show white while in state ON).
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   video_on, x, y        active-video flag and pixel position (stage 0)
//   bg_rgb                background colour aligned with x/y
//   frame_tick, hit       one-cycle pulses: frame start, player damaged
//   rom_row, rom_col      combinational ROM address
//   rom_color             ROM data, one cycle after the address
//   rgb_out, sprite_on    registered composited pixel, opaque-sprite flag (2 clk after x/y)
//   blinking              registered: blink sequence in progress
module blood_sprite_draw #(
    parameter int X0            = 100,
    parameter int Y0            = 40,
    parameter int SPR_W         = 64,
    parameter int SPR_H         = 64,
    parameter int BLINK_FRAMES  = 8,
    parameter int BLINK_TOGGLES = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        video_on,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic [11:0] bg_rgb,
    input  logic        frame_tick,
    input  logic        hit,
    output logic [5:0]  rom_row,
    output logic [5:0]  rom_col,
    input  logic [11:0] rom_color,
    output logic [11:0] rgb_out,
    output logic        sprite_on,
    output logic        blinking
);

    localparam int FW = (BLINK_FRAMES  > 1) ? $clog2(BLINK_FRAMES)  : 1;
    localparam int TW = (BLINK_TOGGLES > 1) ? $clog2(BLINK_TOGGLES) : 1;

    localparam logic [FW-1:0] F_RELOAD = FW'(BLINK_FRAMES - 1);
    localparam logic [TW-1:0] T_RELOAD = TW'(BLINK_TOGGLES - 1);

    // 11-bit bounds so X0+SPR_W cannot overflow the 10-bit coordinate range
    localparam logic [10:0] X_LO  = 11'(X0);
    localparam logic [10:0] X_HI  = 11'(X0 + SPR_W);
    localparam logic [10:0] Y_LO  = 11'(Y0);
    localparam logic [10:0] Y_HI  = 11'(Y0 + SPR_H);
    localparam logic [10:0] X_MAX = 11'd640;
    localparam logic [10:0] Y_MAX = 11'd480;

    // Only the low 6 bits of the offset are needed: (x-X0) mod 64 = x[5:0]-X0[5:0]
    localparam logic [5:0] X0_L = 6'(X0);
    localparam logic [5:0] Y0_L = 6'(Y0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OFF  = 2'd1,
        ON   = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [FW-1:0] fcnt, fcnt_n;
    logic [TW-1:0] tcnt, tcnt_n;

    logic [10:0] xe, ye;
    logic        in_win;
    logic        win_d, von_d;
    logic [11:0] bg_d;
    logic        vis;
    logic        opaque;
    logic [11:0] spr_color;

    // ---------------- Stage 0: window test and ROM address ----------------
    assign xe = {1'b0, x};
    assign ye = {1'b0, y};

    // The X_MAX/Y_MAX terms drop window parts that fall off the visible screen
    assign in_win = (xe >= X_LO) && (xe < X_HI) && (xe < X_MAX) &&
                    (ye >= Y_LO) && (ye < Y_HI) && (ye < Y_MAX);

    assign rom_col = in_win ? (x[5:0] - X0_L) : 6'd0;
    assign rom_row = in_win ? (y[5:0] - Y0_L) : 6'd0;

    // ---------------- Stage 2 combinational terms ----------------
    // The current state register applies to the pixel entering stage 2 now,
    // so a state change is seen one cycle after the edge that made it.
    assign vis    = (state != OFF);
    assign opaque = win_d && (rom_color != 12'h000) && vis;

`ifdef BLOOD_FLASH_EN
    assign spr_color = (state == ON) ? 12'hFFF : rom_color;
`else
    assign spr_color = rom_color;
`endif

    // ---------------- Pixel pipeline ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            win_d     <= 1'b0;
            von_d     <= 1'b0;
            bg_d      <= 12'h000;
            rgb_out   <= 12'h000;
            sprite_on <= 1'b0;
        end else begin
            win_d <= in_win;
            von_d <= video_on;
            bg_d  <= bg_rgb;
            if (!von_d) begin
                rgb_out   <= 12'h000;
                sprite_on <= 1'b0;
            end else if (opaque) begin
                rgb_out   <= spr_color;
                sprite_on <= 1'b1;
            end else begin
                rgb_out   <= bg_d;
                sprite_on <= 1'b0;
            end
        end
    end

    // ---------------- Blink FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            fcnt     <= '0;
            tcnt     <= '0;
            blinking <= 1'b0;
        end else begin
            state    <= state_n;
            fcnt     <= fcnt_n;
            tcnt     <= tcnt_n;
            blinking <= (state_n != IDLE);
        end
    end

    always_comb begin
        state_n = state;
        fcnt_n  = fcnt;
        tcnt_n  = tcnt;
        if (hit) begin
            // hit takes priority over a coincident frame_tick
            state_n = OFF;
            fcnt_n  = F_RELOAD;
            tcnt_n  = T_RELOAD;
        end else begin
            case (state)
                OFF, ON: begin
                    if (frame_tick) begin
                        if (fcnt != '0) begin
                            fcnt_n = fcnt - 1'b1;
                        end else if (tcnt != '0) begin
                            state_n = (state == OFF) ? ON : OFF;
                            tcnt_n  = tcnt - 1'b1;
                            fcnt_n  = F_RELOAD;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
                IDLE:    state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

endmodule
